// File: rtl/id_zflag_branch_unit_pkg.sv
// Shared definitions for the ID-stage Z-flag branch unit.
//   - FSM state encoding (RUN: normal issue, WAIT: one-cycle Z-hazard stall)
//   - Branch-condition encoding carried on id_bne
//   - br_cond(): evaluates a Z-conditional branch against a selected Z value
package id_zflag_branch_unit_pkg;

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  typedef enum logic {
    S_RUN  = ST_RUN,
    S_WAIT = ST_WAIT
  } state_t;

  // id_bne encoding: beq branches on Z==1, bne branches on Z==0.
  localparam logic BR_BEQ = 1'b0;
  localparam logic BR_BNE = 1'b1;

  function automatic logic br_cond(input logic bne, input logic z);
    return (bne == BR_BNE) ? ~z : z;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk  : clock
//   clrn : asynchronous active-high clear
//   en   : count enable; the value holds when low
//   cnt  : current count, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/id_zflag_branch_unit.sv
// ID-stage resolver for Z-conditional branches (beq/bne).
// Tracks whether the instruction in EXE will write Z. A branch that depends
// on it either takes the EXE ALU zero result directly (FWD_EXE=1) or stalls
// one cycle until the writer reaches the MEM-stage Z holder (FWD_EXE=0).
//   clk, clrn  : clock, asynchronous active-high reset
//   id_valid   : ID holds a real instruction
//   id_branch  : ID instruction is a Z-conditional branch
//   id_bne     : 1 = branch on Z==0, 0 = branch on Z==1
//   id_wz      : ID instruction writes Z (ignored for branches)
//   exe_z      : ALU zero result of the instruction in EXE
//   mem_z      : architectural Z held at MEM
//   stall_in   : external freeze of ID/EXE
//   flush      : kill the ID instruction
//   br_taken   : branch in ID resolves taken this cycle
//   z_stall    : hold PC and IF/ID, inject a bubble into EXE
//   exe_wz_q   : instruction in EXE writes Z
//   stall_cnt  : saturating count of z_stall cycles
module id_zflag_branch_unit
  import id_zflag_branch_unit_pkg::*;
#(
  parameter bit FWD_EXE = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_bne,
  input  logic             id_wz,
  input  logic             exe_z,
  input  logic             mem_z,
  input  logic             stall_in,
  input  logic             flush,
  output logic             br_taken,
  output logic             z_stall,
  output logic             exe_wz_q,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t state_q;
  state_t state_d;
  logic   br;
  logic   hazard;
  logic   zsel;
  logic   exe_wz_d;

  assign br     = id_valid & id_branch & ~flush;
  assign hazard = br & exe_wz_q;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    zsel     = mem_z;
    z_stall  = 1'b0;
    br_taken = 1'b0;
    state_d  = state_q;
    exe_wz_d = exe_wz_q;

    // In WAIT the Z writer has reached MEM, so mem_z is already correct.
    if (state_q == S_RUN && hazard) begin
      if (FWD_EXE) zsel = exe_z;
      else         z_stall = 1'b1;
    end

    br_taken = br & ~z_stall & br_cond(id_bne, zsel);

    if (!stall_in) begin
      if (state_q == S_RUN) state_d = z_stall ? S_WAIT : S_RUN;
      else                  state_d = S_RUN;

      // A stalled or flushed ID slot becomes a bubble in EXE; branches never
      // write Z even if id_wz is set alongside id_branch.
      if (z_stall || flush) exe_wz_d = 1'b0;
      else                  exe_wz_d = id_valid & id_wz & ~id_branch;
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_q  <= S_RUN;
      exe_wz_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      exe_wz_q <= exe_wz_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clrn (clrn),
    .en   (z_stall & ~stall_in),
    .cnt  (stall_cnt)
  );

endmodule

// File: tb/tb_id_zflag_branch_unit.sv
// Directed bench for id_zflag_branch_unit. Three instances share the inputs:
// u_stall (FWD_EXE=0, 16-bit count), u_fwd (FWD_EXE=1) and u_sat
// (FWD_EXE=0, 2-bit count). Inputs change 1 time unit after a rising edge
// and outputs are sampled 2 units later, well away from either edge.
module tb_id_zflag_branch_unit;

  logic clk  = 1'b0;
  logic clrn = 1'b1;
  logic id_valid, id_branch, id_bne, id_wz, exe_z, mem_z, stall_in, flush;

  logic        s_br_taken, s_z_stall, s_exe_wz_q;
  logic [15:0] s_stall_cnt;
  logic        f_br_taken, f_z_stall, f_exe_wz_q;
  logic [15:0] f_stall_cnt;
  logic        q_br_taken, q_z_stall, q_exe_wz_q;
  logic [1:0]  q_stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_zflag_branch_unit #(.FWD_EXE(1'b0), .CNT_W(16)) u_stall (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_branch(id_branch),
    .id_bne(id_bne), .id_wz(id_wz), .exe_z(exe_z), .mem_z(mem_z),
    .stall_in(stall_in), .flush(flush), .br_taken(s_br_taken),
    .z_stall(s_z_stall), .exe_wz_q(s_exe_wz_q), .stall_cnt(s_stall_cnt)
  );

  id_zflag_branch_unit #(.FWD_EXE(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_branch(id_branch),
    .id_bne(id_bne), .id_wz(id_wz), .exe_z(exe_z), .mem_z(mem_z),
    .stall_in(stall_in), .flush(flush), .br_taken(f_br_taken),
    .z_stall(f_z_stall), .exe_wz_q(f_exe_wz_q), .stall_cnt(f_stall_cnt)
  );

  id_zflag_branch_unit #(.FWD_EXE(1'b0), .CNT_W(2)) u_sat (
    .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_branch(id_branch),
    .id_bne(id_bne), .id_wz(id_wz), .exe_z(exe_z), .mem_z(mem_z),
    .stall_in(stall_in), .flush(flush), .br_taken(q_br_taken),
    .z_stall(q_z_stall), .exe_wz_q(q_exe_wz_q), .stall_cnt(q_stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v, input logic b, input logic bne,
                       input logic wz, input logic ez, input logic mz,
                       input logic stl, input logic fl);
    id_valid  = v;
    id_branch = b;
    id_bne    = bne;
    id_wz     = wz;
    exe_z     = ez;
    mem_z     = mz;
    stall_in  = stl;
    flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    tick();
    idle();
    clrn = 1'b1;
    tick();
    clrn = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    idle();
    clrn = 1'b1;
    settle();
    checks++; if (s_z_stall !== 1'b0) begin failures++; $display("FAIL rst_z_stall got=%b exp=0", s_z_stall); end
    checks++; if (s_br_taken !== 1'b0) begin failures++; $display("FAIL rst_br_taken got=%b exp=0", s_br_taken); end
    checks++; if (s_exe_wz_q !== 1'b0) begin failures++; $display("FAIL rst_exe_wz_q got=%b exp=0", s_exe_wz_q); end
    checks++; if (s_stall_cnt !== 16'd0) begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", s_stall_cnt); end
    tick();
    clrn = 1'b0;
    // beq with Z=1 at MEM and no writer in EXE: taken immediately.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checks++; if (s_br_taken !== 1'b1) begin failures++; $display("FAIL nohaz_beq_taken got=%b exp=1", s_br_taken); end
    checks++; if (s_z_stall !== 1'b0) begin failures++; $display("FAIL nohaz_z_stall got=%b exp=0", s_z_stall); end
    checks++; if (s_stall_cnt !== 16'd0) begin failures++; $display("FAIL nohaz_stall_cnt got=%0d exp=0", s_stall_cnt); end
    // bne with Z=1: not taken.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checks++; if (s_br_taken !== 1'b0) begin failures++; $display("FAIL nohaz_bne_taken got=%b exp=0", s_br_taken); end
    // Flushed beq that would otherwise be taken.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    checks++; if (s_br_taken !== 1'b0) begin failures++; $display("FAIL flush_beq_taken got=%b exp=0", s_br_taken); end
    // Invalid slot never branches.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checks++; if (s_br_taken !== 1'b0) begin failures++; $display("FAIL invalid_taken got=%b exp=0", s_br_taken); end
  endtask

  task automatic test_stall_path();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // cmp, writes Z
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  // beq, exe_z=1, mem_z=0
    settle();
    checks++; if (s_exe_wz_q !== 1'b1) begin failures++; $display("FAIL stall_exe_wz_q got=%b exp=1", s_exe_wz_q); end
    checks++; if (s_z_stall !== 1'b1) begin failures++; $display("FAIL stall_c1_z_stall got=%b exp=1", s_z_stall); end
    checks++; if (s_br_taken !== 1'b0) begin failures++; $display("FAIL stall_c1_br_taken got=%b exp=0", s_br_taken); end
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // same beq, mem_z now 1
    settle();
    checks++; if (s_br_taken !== 1'b1) begin failures++; $display("FAIL stall_c2_br_taken got=%b exp=1", s_br_taken); end
    checks++; if (s_z_stall !== 1'b0) begin failures++; $display("FAIL stall_c2_z_stall got=%b exp=0", s_z_stall); end
    checks++; if (s_stall_cnt !== 16'd1) begin failures++; $display("FAIL stall_c2_cnt got=%0d exp=1", s_stall_cnt); end
    checks++; if (s_exe_wz_q !== 1'b0) begin failures++; $display("FAIL stall_c2_exe_wz_q got=%b exp=0", s_exe_wz_q); end
    tick();
    idle();
  endtask

  task automatic test_forward_path();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // cmp
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // bne, exe_z=0, mem_z=1
    settle();
    checks++; if (f_br_taken !== 1'b1) begin failures++; $display("FAIL fwd_br_taken got=%b exp=1", f_br_taken); end
    checks++; if (f_z_stall !== 1'b0) begin failures++; $display("FAIL fwd_z_stall got=%b exp=0", f_z_stall); end
    checks++; if (s_z_stall !== 1'b1) begin failures++; $display("FAIL fwd_ref_z_stall got=%b exp=1", s_z_stall); end
    tick();
    idle();
    settle();
    checks++; if (f_stall_cnt !== 16'd0) begin failures++; $display("FAIL fwd_stall_cnt got=%0d exp=0", f_stall_cnt); end
    checks++; if (f_exe_wz_q !== 1'b0) begin failures++; $display("FAIL fwd_exe_wz_q got=%b exp=0", f_exe_wz_q); end
    tick();
  endtask

  task automatic test_freeze();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // cmp
    tick();
    // Hazard beq frozen in RUN: nothing advances.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      checks++; if (s_z_stall !== 1'b1) begin failures++; $display("FAIL frz_run_z_stall[%0d] got=%b exp=1", i, s_z_stall); end
      checks++; if (s_exe_wz_q !== 1'b1) begin failures++; $display("FAIL frz_run_exe_wz_q[%0d] got=%b exp=1", i, s_exe_wz_q); end
      checks++; if (s_stall_cnt !== 16'd0) begin failures++; $display("FAIL frz_run_cnt[%0d] got=%0d exp=0", i, s_stall_cnt); end
    end
    stall_in = 1'b0;
    tick();  // RUN -> WAIT, one stall counted
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);  // frozen in WAIT
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      checks++; if (s_z_stall !== 1'b0) begin failures++; $display("FAIL frz_wait_z_stall[%0d] got=%b exp=0", i, s_z_stall); end
      checks++; if (s_exe_wz_q !== 1'b0) begin failures++; $display("FAIL frz_wait_exe_wz_q[%0d] got=%b exp=0", i, s_exe_wz_q); end
      checks++; if (s_stall_cnt !== 16'd1) begin failures++; $display("FAIL frz_wait_cnt[%0d] got=%0d exp=1", i, s_stall_cnt); end
    end
    stall_in = 1'b0;
    settle();
    checks++; if (s_br_taken !== 1'b1) begin failures++; $display("FAIL frz_release_br_taken got=%b exp=1", s_br_taken); end
    checks++; if (s_z_stall !== 1'b0) begin failures++; $display("FAIL frz_release_z_stall got=%b exp=0", s_z_stall); end
    tick();
    idle();
  endtask

  task automatic test_flush_wait();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // cmp
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // hazard beq
    settle();
    checks++; if (s_z_stall !== 1'b1) begin failures++; $display("FAIL flw_enter_z_stall got=%b exp=1", s_z_stall); end
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);  // flush in WAIT
    settle();
    checks++; if (s_br_taken !== 1'b0) begin failures++; $display("FAIL flw_br_taken got=%b exp=0", s_br_taken); end
    checks++; if (s_z_stall !== 1'b0) begin failures++; $display("FAIL flw_z_stall got=%b exp=0", s_z_stall); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // cmp
    settle();
    checks++; if (s_exe_wz_q !== 1'b0) begin failures++; $display("FAIL flw_exe_wz_q got=%b exp=0", s_exe_wz_q); end
    tick();
    // A hazard stall here proves the FSM went back to RUN.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    checks++; if (s_z_stall !== 1'b1) begin failures++; $display("FAIL flw_back_in_run got=%b exp=1", s_z_stall); end
    tick();
    // Flushed Z writer in RUN becomes a bubble in EXE.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    settle();
    checks++; if (s_exe_wz_q !== 1'b0) begin failures++; $display("FAIL flush_run_exe_wz_q got=%b exp=0", s_exe_wz_q); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // cmp #1
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // cmp #2
    settle();
    checks++; if (s_z_stall !== 1'b0) begin failures++; $display("FAIL b2b_nonbranch_z_stall got=%b exp=0", s_z_stall); end
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  // beq, exe_z=1, mem_z=0
    settle();
    checks++; if (s_z_stall !== 1'b1) begin failures++; $display("FAIL b2b_z_stall got=%b exp=1", s_z_stall); end
    checks++; if (f_br_taken !== 1'b1) begin failures++; $display("FAIL b2b_fwd_br_taken got=%b exp=1", f_br_taken); end
    tick();
    idle();
    tick();
    // Writer then non-writer: the branch sees no hazard and uses mem_z.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  // bne, mem_z=0
    settle();
    checks++; if (s_z_stall !== 1'b0) begin failures++; $display("FAIL gap_z_stall got=%b exp=0", s_z_stall); end
    checks++; if (s_br_taken !== 1'b1) begin failures++; $display("FAIL gap_br_taken got=%b exp=1", s_br_taken); end
    // Branch with id_wz set: id_wz is ignored.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    settle();
    checks++; if (s_exe_wz_q !== 1'b0) begin failures++; $display("FAIL br_wz_ignored got=%b exp=0", s_exe_wz_q); end
  endtask

  task automatic test_saturation_async_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      checks++; if (q_z_stall !== 1'b1) begin failures++; $display("FAIL sat_z_stall[%0d] got=%b exp=1", i, q_z_stall); end
      tick();
      idle();
      tick();
    end
    settle();
    checks++; if (q_stall_cnt !== 2'd3) begin failures++; $display("FAIL sat_cnt got=%0d exp=3", q_stall_cnt); end
    checks++; if (s_stall_cnt !== 16'd5) begin failures++; $display("FAIL wide_cnt got=%0d exp=5", s_stall_cnt); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    checks++; if (s_z_stall !== 1'b1) begin failures++; $display("FAIL arst_pre_z_stall got=%b exp=1", s_z_stall); end
    clrn = 1'b1;  // between edges
    #1;
    checks++; if (s_z_stall !== 1'b0) begin failures++; $display("FAIL arst_z_stall got=%b exp=0", s_z_stall); end
    checks++; if (s_br_taken !== 1'b0) begin failures++; $display("FAIL arst_br_taken got=%b exp=0", s_br_taken); end
    checks++; if (s_exe_wz_q !== 1'b0) begin failures++; $display("FAIL arst_exe_wz_q got=%b exp=0", s_exe_wz_q); end
    checks++; if (s_stall_cnt !== 16'd0) begin failures++; $display("FAIL arst_cnt got=%0d exp=0", s_stall_cnt); end
    checks++; if (q_stall_cnt !== 2'd0) begin failures++; $display("FAIL arst_sat_cnt got=%0d exp=0", q_stall_cnt); end
    tick();
    clrn = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_stall_path();
    test_forward_path();
    test_freeze();
    test_flush_wait();
    test_back_to_back();
    test_saturation_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
